// File: rtl/uart_word_cmd.sv
// Command stage between the UART byte widener and narrower: decodes 32-bit
// command words, drives the LED, and returns one response word per accepted input.
module uart_word_cmd #(
  parameter logic [31:0] on_code_p     = 32'h00B835F2,
  parameter logic [31:0] off_code_p    = 32'hC0C0FFEE,
  parameter logic [31:0] ack_on_p      = 32'h4F4E4F4B,
  parameter logic [31:0] ack_off_p     = 32'h4F46464B,
  parameter logic [31:0] nak_p         = 32'h4E414B21,
  parameter int          count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [31:0]              s_axis_tdata_i,
  input  logic [3:0]               s_axis_tkeep_i,
  input  logic                     s_axis_tlast_i,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  output logic [31:0]              m_axis_tdata_o,
  output logic [3:0]               m_axis_tkeep_o,
  output logic                     m_axis_tlast_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     led_o,
  output logic                     err_o,
  output logic [count_width_p-1:0] word_count_o
);

  // Handshake: a word moves on either side only in a cycle where valid and
  // ready are both high; the output holds data/keep/last/valid until taken.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                     state_q;
  logic [31:0]                data_q;
  logic [3:0]                 keep_q;
  logic                       last_q;
  logic                       led_q;
  logic                       err_q;
  logic [count_width_p-1:0]   count_q;

  logic                       accept;
  logic                       partial;
  logic [31:0]                resp_data;
  logic                       led_next;
  logic                       unused_tlast;

  // Frame boundaries carry no meaning for single-word commands.
  assign unused_tlast = s_axis_tlast_i;

  assign s_axis_tready_o = !reset_i && ((state_q == ST_EMPTY) || m_axis_tready_i);
  assign accept          = s_axis_tvalid_i && s_axis_tready_o;
  assign partial         = (s_axis_tkeep_i != 4'hF);

  always_comb begin
    resp_data = s_axis_tdata_i;
    led_next  = led_q;
    if (partial) begin
      resp_data = nak_p;
    end else if (s_axis_tdata_i == on_code_p) begin
      resp_data = ack_on_p;
      led_next  = 1'b1;
    end else if (s_axis_tdata_i == off_code_p) begin
      resp_data = ack_off_p;
      led_next  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) state_q <= ST_FULL;
        end
        ST_FULL: begin
          // Accept while draining reloads the register with no bubble.
          if (m_axis_tready_i && !accept) state_q <= ST_EMPTY;
        end
        default: state_q <= ST_EMPTY;
      endcase
      if (accept) begin
        data_q <= resp_data;
        keep_q <= 4'hF;
        last_q <= 1'b1;
        led_q  <= led_next;
        if (partial) err_q <= 1'b1;
        if (count_q != {count_width_p{1'b1}}) count_q <= count_q + count_width_p'(1);
      end
    end
  end

  assign m_axis_tvalid_o = (state_q == ST_FULL);
  assign m_axis_tdata_o  = data_q;
  assign m_axis_tkeep_o  = keep_q;
  assign m_axis_tlast_o  = last_q;
  assign led_o           = led_q;
  assign err_o           = err_q;
  assign word_count_o    = count_q;

endmodule
